kypd_scanner: RTL and testbench
===============================

# kypd_scanner

Scanner for the 4x4 Pmod keypad (KYPD). Where the segment display multiplexer drives a digit select and pushes segment data out, this block drives the keypad columns, reads the rows back, debounces the result, and reports single key presses as hex codes with a one-cycle strobe. It sits on the board-input side of the design, next to the display path, and typically feeds key codes into the digit registers shown on the display.

## Interface
- `SETTLE_CYCLES`, default 1000: cycles each column is driven low before its rows are sampled. Minimum 3, to cover the synchronizer.
- `DEBOUNCE_SCANS`, default 4: number of identical consecutive full scans required before a result is accepted. Minimum 1.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `row`  in  4  keypad rows, active-low (pulled up; a pressed key pulls its row low when its column is low). Asynchronous.
- `col`  out  4  keypad column drive, active-low, exactly one bit low at all times.
- `key_code`  out  4  hex legend of the last accepted key.
- `key_valid`  out  1  one-cycle strobe: a new key was accepted this cycle.
- `key_down`  out  1  level: a single debounced key is currently held.
- `multi`  out  1  level: more than one key is stably pressed.

## Operation
- `row` passes through a 2-flop synchronizer before use.
- Scan loop over column index c = 0..3:
  - `col` = ~(1<<c).
  - A settle counter runs over SETTLE_CYCLES cycles.
  - On the last cycle of the column window, the synchronized rows (inverted) are stored as 4 bits of a 16-bit scan vector at bits [4c+3:4c].
  - c then wraps 3 -> 0.
- Keymap, indexed [row][col] and matching the KYPD legend: r0: 1 2 3 A; r1: 4 5 6 B; r2: 7 8 9 C; r3: 0 F E D.
- End-of-scan evaluation, performed the cycle after the c=3 sample, classifies the scan vector:
  - NONE: popcount 0.
  - SINGLE(code): popcount 1.
  - MULTI: popcount > 1.
- Debounce:
  - If the class and code equal those of the previous scan, the stable counter increments, saturating at DEBOUNCE_SCANS.
  - Otherwise the stable counter is set to 1 and the previous-scan result is replaced.
- Acceptance, evaluated only when the stable counter is equal to DEBOUNCE_SCANS:
  - SINGLE(k) with `key_down`=0, or with `key_down`=1 and `key_code`≠k: `key_code`<=k, `key_valid`=1 for one cycle, `key_down`=1, `multi`=0.
  - SINGLE(k) with `key_down`=1 and `key_code`=k: no change, no strobe.
  - NONE: `key_down`=0, `multi`=0. `key_code` holds its value.
  - MULTI: `multi`=1, `key_down`=0, no strobe. `key_code` holds its value.
- Boundary cases:
  - Rolling from key A directly to key B yields a second strobe once B is stable.
  - Releasing and re-pressing the same key yields a new strobe.
  - The stable counter saturates and never wraps.

## Timing
- Column window = SETTLE_CYCLES cycles. Scan period = 4*SETTLE_CYCLES cycles.
- `col` is registered. It changes on the cycle after the previous column's sample.
- `key_valid`, `key_down`, `multi` and `key_code` update on the same edge, one cycle after the c=3 sample cycle.
- Minimum press-to-strobe latency is DEBOUNCE_SCANS full scans plus up to one partial scan.
- Reset values:
  - `col`=4'b1110.
  - `key_code`=0, `key_valid`=0, `key_down`=0, `multi`=0.
  - c=0, settle counter=0, stable counter=0, previous result=NONE.
  - Synchronizer flops = 4'b1111.
- Reset asserted mid-scan discards the partial scan and the debounce history; scanning restarts at column 0.
- `key_valid` is never asserted during reset or in the cycle that reset is released.

## Structure
- Package `kypd_pkg` holds:
  - the 16-entry keymap constant (row/col -> hex);
  - the result-class type (NONE/SINGLE/MULTI);
  - the scan FSM state type (SETTLE, SAMPLE, EVAL).
- One natural sub-module: `sync_2ff`, a parameterized-width 2-flop synchronizer, reset to all ones. It is reusable for the switch and button inputs.
- All other logic (scan FSM, popcount/encode, debounce) stays in `kypd_scanner`.

## Test plan
Bench parameters: SETTLE_CYCLES=4, DEBOUNCE_SCANS=2, scan period 16 cycles. The bench keypad model drives row[r]=0 iff col[c]=0 and key (r,c) is pressed.

- **Reset and scan sequence:** hold `rst_n`=0 for 3 cycles, then release. Required: all outputs are 0 and `col`=1110 during reset; afterwards `col` cycles 1110, 1101, 1011, 0111 for 4 cycles each and repeats.
- **Single press '5' (r1,c1):** press from reset release. Required: exactly one `key_valid`, with `key_code`=5 and `key_down`=1. Hold for 10 scans: no further strobes. Release: `key_down`=0 after 2 scans, and `key_code` stays 5.
- **Bounce:** toggle '9' every scan for 6 scans. Required: no `key_valid`, and `key_down` stays 0. Then hold '9': one strobe with `key_code`=9.
- **Two keys '1' and '2':** press both together. Required: `multi`=1, `key_down`=0, no strobe. Release '2': one strobe with `key_code`=1, and `multi`=0.
- **Roll:** press 'A', then switch to 'D' without a NONE gap. Required: two strobes, with codes A then D.
- **Reset mid-press:** assert reset during column 2 while 'E' is held. Required: no strobe during reset; a strobe with `key_code`=E no earlier than 2 full scans after reset release.

Source files
------------

// File: rtl/kypd_pkg.sv
// Shared types and constants for the 4x4 Pmod keypad scanner.
//   KEYMAP        : hex legend indexed by {row, col} (row * 4 + col)
//   kypd_class_e  : classification of one full scan (none / single / multi)
//   scan_state_e  : column-scan FSM states
//   scan_result_t : class plus key code (code is 0 unless class is single)
//   classify()    : popcount and encode a 16-bit scan vector
package kypd_pkg;

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_SINGLE,
    CLS_MULTI
  } kypd_class_e;

  typedef enum logic [1:0] {
    ST_SETTLE,
    ST_SAMPLE,
    ST_EVAL
  } scan_state_e;

  typedef struct packed {
    kypd_class_e cls;
    logic [3:0]  code;
  } scan_result_t;

  // KYPD legend: r0: 1 2 3 A, r1: 4 5 6 B, r2: 7 8 9 C, r3: 0 F E D
  localparam logic [3:0] KEYMAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

  // Scan vector bit 4*c + r holds key (r, c); the keymap wants r*4 + c,
  // so the two 2-bit halves of the bit index are swapped.
  function automatic scan_result_t classify(input logic [15:0] vec);
    scan_result_t res;
    logic [4:0]   cnt;
    logic [3:0]   code;
    cnt  = '0;
    code = '0;
    for (int i = 0; i < 16; i++) begin
      if (vec[i]) begin
        cnt  = cnt + 5'd1;
        code = KEYMAP[{i[1:0], i[3:2]}];
      end
    end
    if (cnt == 5'd0) begin
      res.cls  = CLS_NONE;
      res.code = '0;
    end else if (cnt == 5'd1) begin
      res.cls  = CLS_SINGLE;
      res.code = code;
    end else begin
      res.cls  = CLS_MULTI;
      res.code = '0;
    end
    return res;
  endfunction

endpackage

// File: rtl/kypd_scanner_if.sv
// Key-event bus from the keypad scanner to its consumer.
//   key_code  : hex legend of the last accepted key
//   key_valid : one-cycle strobe, a new key was accepted
//   key_down  : a single debounced key is held
//   multi     : more than one key is stably pressed
// master = scanner (drives), slave = consumer (reads).
interface kypd_scanner_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;
  logic       multi;

  modport master (output key_code, output key_valid, output key_down, output multi);
  modport slave  (input  key_code, input  key_valid, input  key_down, input  multi);
endinterface

// File: rtl/sync_2ff.sv
// Parameterized-width two-flop synchronizer for asynchronous board inputs.
// Resets to all ones, matching idle pulled-up inputs.
//   clk, rst_n : clock, synchronous active-low reset
//   d          : asynchronous input
//   q          : synchronized output
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its source; blocking here would collapse
  // the two stages into one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/kypd_scanner.sv
// 4x4 keypad scanner: drives one column low at a time, samples the rows,
// debounces complete scans and reports single key presses.
//   clk, rst_n : clock, synchronous active-low reset
//   row        : keypad rows, active-low, asynchronous
//   col        : column drive, active-low, exactly one bit low
//   key_if     : key_code / key_valid / key_down / multi
module kypd_scanner
  import kypd_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         row,
  output logic [3:0]         col,
  kypd_scanner_if.master     key_if
);

  localparam int CW = $clog2(SETTLE_CYCLES);
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CNT_PRE_SAMPLE = CW'(SETTLE_CYCLES - 2);
  localparam logic [SW-1:0] STABLE_MAX     = SW'(DEBOUNCE_SCANS);

  logic [3:0]   row_s;
  scan_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]   col_idx_q, col_idx_d;
  logic [15:0]  scan_q, scan_d;

  scan_result_t cur, prev_q;
  logic [SW-1:0] stable_q, stable_d;
  logic [3:0]   key_code_q;
  logic         key_valid_q, key_down_q, multi_q;

  sync_2ff #(.WIDTH(4)) u_row_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (row),
    .q     (row_s)
  );

  // The EVAL cycle is also the first cycle of the column-0 window, so the
  // scan period stays exactly 4 * SETTLE_CYCLES.
  // NOTE: every signal written here gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    col_idx_d = col_idx_q;
    scan_d    = scan_q;
    unique case (state_q)
      ST_SETTLE, ST_EVAL: begin
        state_d = (cnt_q == CNT_PRE_SAMPLE) ? ST_SAMPLE : ST_SETTLE;
      end
      ST_SAMPLE: begin
        scan_d[{col_idx_q, 2'b00} +: 4] = ~row_s;
        cnt_d     = '0;
        col_idx_d = col_idx_q + 2'd1;
        state_d   = (col_idx_q == 2'd3) ? ST_EVAL : ST_SETTLE;
      end
      default: state_d = ST_SETTLE;
    endcase
  end

  // NOTE: the scan vector is reset as well, although each scan overwrites
  // all 16 bits, so nothing downstream can ever see X after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_SETTLE;
      cnt_q     <= '0;
      col_idx_q <= '0;
      scan_q    <= '0;
      col       <= 4'b1110;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      col_idx_q <= col_idx_d;
      scan_q    <= scan_d;
      col       <= ~(4'b0001 << col_idx_d);
    end
  end

  assign cur = classify(scan_q);

  // Stable counter saturates at DEBOUNCE_SCANS; any change restarts at 1.
  always_comb begin
    if (cur == prev_q) begin
      stable_d = (stable_q == STABLE_MAX) ? stable_q : stable_q + 1'b1;
    end else begin
      stable_d = SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q      <= '{cls: CLS_NONE, code: 4'h0};
      stable_q    <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
      multi_q     <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (state_q == ST_EVAL) begin
        prev_q   <= cur;
        stable_q <= stable_d;
        if (stable_d == STABLE_MAX) begin
          unique case (cur.cls)
            CLS_SINGLE: begin
              // A held key reports once; a different key (roll) reports again.
              if (!key_down_q || key_code_q != cur.code) begin
                key_code_q  <= cur.code;
                key_valid_q <= 1'b1;
              end
              key_down_q <= 1'b1;
              multi_q    <= 1'b0;
            end
            CLS_MULTI: begin
              key_down_q <= 1'b0;
              multi_q    <= 1'b1;
            end
            default: begin
              key_down_q <= 1'b0;
              multi_q    <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign key_if.key_code  = key_code_q;
  assign key_if.key_valid = key_valid_q;
  assign key_if.key_down  = key_down_q;
  assign key_if.multi     = multi_q;

endmodule

// File: tb/tb_kypd_scanner.sv
// Self-checking bench for kypd_scanner (SETTLE_CYCLES=4, DEBOUNCE_SCANS=2).
// A keypad model drives the rows from the pressed-key set; a scan-level
// reference model predicts each evaluation, and a monitor compares.
module tb_kypd_scanner;

  localparam int S  = 4;
  localparam int DB = 2;
  localparam int P  = 4 * S;

  typedef struct {
    logic       valid;
    logic [3:0] code;
    logic       down;
    logic       multi;
  } exp_t;

  typedef struct {
    int cls;   // 0 none, 1 single, 2 multi
    int code;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] pressed = '0;   // bit r*4 + c = key (r, c) held

  kypd_scanner_if kif ();

  kypd_scanner #(.SETTLE_CYCLES(S), .DEBOUNCE_SCANS(DB)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .row    (row),
    .col    (col),
    .key_if (kif)
  );

  always #5 clk = ~clk;

  // Keypad: a row reads low when a pressed key connects it to the low column.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  logic [3:0] legend [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  res_t hist[$];
  logic [3:0] m_code = 4'h0;
  logic m_down = 1'b0, m_multi = 1'b0;

  // Cycles since reset release, and whether the last edge was in reset.
  int   t = 0;
  logic rst_q = 1'b0;
  always @(posedge clk) begin
    rst_q <= rst_n;
    if (!rst_n) t <= 0;
    else        t <= t + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0d)", name, act, req, t);
    end
  endtask

  function automatic logic [15:0] kb(input int r, input int c);
    logic [15:0] m;
    m = '0;
    m[r*4+c] = 1'b1;
    return m;
  endfunction

  function automatic void model_reset();
    hist.delete();
    exp_q.delete();
    m_code  = 4'h0;
    m_down  = 1'b0;
    m_multi = 1'b0;
  endfunction

  // Predict the evaluation of one full scan with key set m.
  function automatic void model_scan(input logic [15:0] m);
    res_t res;
    exp_t e;
    int   n, run;
    n        = $countones(m);
    res.cls  = (n == 0) ? 0 : (n == 1) ? 1 : 2;
    res.code = 0;
    for (int i = 0; i < 16; i++) if (n == 1 && m[i]) res.code = int'(legend[i]);
    hist.push_back(res);
    run = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i].cls != res.cls || hist[i].code != res.code) break;
      run++;
    end
    e.valid = 1'b0;
    if (run >= DB) begin
      if (res.cls == 1) begin
        if (!m_down || m_code != 4'(res.code)) begin
          e.valid = 1'b1;
          m_code  = 4'(res.code);
        end
        m_down  = 1'b1;
        m_multi = 1'b0;
      end else if (res.cls == 2) begin
        m_down  = 1'b0;
        m_multi = 1'b1;
      end else begin
        m_down  = 1'b0;
        m_multi = 1'b0;
      end
    end
    e.code  = m_code;
    e.down  = m_down;
    e.multi = m_multi;
    exp_q.push_back(e);
  endfunction

  // Apply key set m for the scan just starting; return at the next scan start.
  task automatic apply_scan(input logic [15:0] m);
    bit found;
    pressed = m;
    model_scan(m);
    found = 0;
    @(negedge clk);
    for (int i = 0; i < 2 * P; i++) begin
      if (rst_q && t > 0 && t % P == 0) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL scan_boundary: no scan start within %0d cycles", 2 * P);
    end
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    model_reset();
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: reset values, column sequence, per-evaluation outputs, stray strobes.
  always @(negedge clk) begin
    logic [3:0] ec;
    exp_t e;
    if (!rst_q) begin
      check("rst_col",   col, 4'b1110);
      check("rst_valid", kif.key_valid, 1'b0);
      check("rst_down",  kif.key_down, 1'b0);
      check("rst_multi", kif.multi, 1'b0);
      check("rst_code",  kif.key_code, 4'h0);
    end else begin
      ec = ~(4'b0001 << ((t / S) % 4));
      check("col_seq", col, ec);
      if (t > P && t % P == 1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL eval_unexpected: evaluation with no prediction (t=%0d)", t);
        end else begin
          e = exp_q.pop_front();
          check("key_valid", kif.key_valid, e.valid);
          check("key_code",  kif.key_code, e.code);
          check("key_down",  kif.key_down, e.down);
          check("multi",     kif.multi, e.multi);
        end
      end else begin
        check("stray_valid", kif.key_valid, 1'b0);
      end
    end
  end

  initial begin
    logic [15:0] m;
    int kind, reps, a, b;
    bit found;

    // Reset and single press '5' from release, hold, release, re-press.
    pressed = '0;
    do_reset(3);
    for (int i = 0; i < 12; i++) apply_scan(kb(1, 1));
    for (int i = 0; i < 3; i++)  apply_scan('0);
    for (int i = 0; i < 3; i++)  apply_scan(kb(1, 1));
    for (int i = 0; i < 3; i++)  apply_scan('0);

    // Bounce '9' every scan, then hold.
    for (int i = 0; i < 6; i++) apply_scan((i % 2 == 0) ? kb(2, 2) : 16'h0);
    for (int i = 0; i < 3; i++) apply_scan(kb(2, 2));
    for (int i = 0; i < 3; i++) apply_scan('0);

    // Two keys '1' and '2', then release '2'.
    for (int i = 0; i < 4; i++) apply_scan(kb(0, 0) | kb(0, 1));
    for (int i = 0; i < 3; i++) apply_scan(kb(0, 0));
    for (int i = 0; i < 3; i++) apply_scan('0);

    // Roll 'A' -> 'D'.
    for (int i = 0; i < 3; i++) apply_scan(kb(0, 3));
    for (int i = 0; i < 3; i++) apply_scan(kb(3, 3));
    for (int i = 0; i < 3; i++) apply_scan('0);

    // Reset during column 2 while 'E' is held.
    for (int i = 0; i < 3; i++) apply_scan(kb(3, 2));
    found = 0;
    for (int i = 0; i < 2 * P; i++) begin
      @(negedge clk);
      if (col == 4'b1011) begin
        found = 1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL col2_wait: column 2 not seen");
    end
    do_reset(3);
    for (int i = 0; i < 4; i++) apply_scan(kb(3, 2));
    for (int i = 0; i < 3; i++) apply_scan('0);

    // Randomized key sets, each held 1-3 scans.
    m = '0;
    for (int n = 0; n < 30; n++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: m = '0;
        1: m = 16'h1 << $urandom_range(0, 15);
        2: begin
          a = $urandom_range(0, 15);
          b = (a + 1 + $urandom_range(0, 14)) % 16;
          m = (16'h1 << a) | (16'h1 << b);
        end
        default: ;
      endcase
      reps = $urandom_range(1, 3);
      for (int i = 0; i < reps; i++) apply_scan(m);
    end

    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL eval_missing: %0d predicted evaluations not observed, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
